// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer that connects two requesters to the
// 256-byte big-endian data memory. Each access takes three cycles: IDLE, ACCESS, RESP.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic                  m0_we,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m0_err,
  output logic                  m1_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] endereco,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state;
  logic                  last;
  logic                  win;
  logic                  lat_aligned;

  logic                  pick;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_aligned;

  // On a tie the port that was not served last wins; otherwise the lone requester wins.
  always_comb begin
    pick        = (m0_req && m1_req) ? ~last : m1_req;
    sel_we      = pick ? m1_we    : m0_we;
    sel_addr    = pick ? m1_addr  : m0_addr;
    sel_wdata   = pick ? m1_wdata : m0_wdata;
    sel_aligned = (sel_addr[2:0] == 3'b000);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      win         <= 1'b0;
      lat_aligned <= 1'b0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      endereco    <= '0;
      write_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state       <= ACCESS;
            win         <= pick;
            last        <= pick;
            lat_aligned <= sel_aligned;
            m0_gnt      <= ~pick;
            m1_gnt      <= pick;
            endereco    <= sel_addr;
            write_data  <= sel_wdata;
            // A misaligned access is still granted, but it never touches the memory.
            mem_read    <= ~sel_we && sel_aligned;
            mem_write   <= sel_we && sel_aligned;
          end
        end
        ACCESS: begin
          state     <= RESP;
          m0_gnt    <= 1'b0;
          m1_gnt    <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (win) begin
            m1_rvalid <= 1'b1;
            m1_err    <= ~lat_aligned;
            m1_rdata  <= lat_aligned ? read_data : '0;
          end else begin
            m0_rvalid <= 1'b1;
            m0_err    <= ~lat_aligned;
            m0_rdata  <= lat_aligned ? read_data : '0;
          end
        end
        RESP: begin
          state     <= IDLE;
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          m0_err    <= 1'b0;
          m1_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural big-endian byte memory.
// A table of accesses feeds a response scoreboard, and hand-written sequences cover ties and reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [63:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [7:0]  endereco;
  logic [63:0] write_data, read_data;

  logic [7:0]  mem [256];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  typedef struct {
    bit          port;
    logic [63:0] rdata;
    bit          err;
    bit          chk_rdata;
  } exp_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    bit          exp_err;
    bit          chk_rdata;
  } vec_t;

  exp_t sb [$];
  vec_t vecs [11];

  dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write), .endereco(endereco),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational big-endian read with byte-address wraparound.
  always_comb begin
    read_data = '0;
    for (int i = 0; i < 8; i++) read_data[63-8*i -: 8] = mem[8'(endereco + 8'(i))];
  end

  // Memory image plus falling-edge write port, kept in one process.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h07] = 8'h08;
    mem[8'h0F] = 8'h06;
    for (int i = 0; i < 8; i++) mem[8'h18 + i] = 8'(8'h11 * (i + 1));
    forever begin
      @(negedge clk);
      if (mem_write)
        for (int i = 0; i < 8; i++) mem[8'(endereco + 8'(i))] = write_data[63-8*i -: 8];
    end
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Pops the scoreboard whenever any requester receives its response.
  always @(negedge clk) begin
    if (!reset && (m0_rvalid || m1_rvalid)) begin
      check64("rvalid_exclusive", 64'(m0_rvalid & m1_rvalid), 64'd0);
      if (sb.size() == 0) begin
        check64("unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check64("rsp_port", 64'(m1_rvalid), 64'(e.port));
        check64("rsp_err", 64'(e.port ? m1_err : m0_err), 64'(e.err));
        if (e.chk_rdata) check64("rsp_rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
      end
    end
  end

  task automatic wait_gnt(input int budget, output int port, output int at);
    bit found = 1'b0;
    port = -1;
    at   = cyc;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin
        found = 1'b1;
        port  = m1_gnt ? 1 : 0;
        at    = cyc;
      end
    end
    if (!found) check64("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic push_exp(input bit port, input logic [63:0] rdata, input bit err);
    exp_t e;
    e.port = port; e.rdata = rdata; e.err = err; e.chk_rdata = 1'b1;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    int   port, at, start;
    bit   aligned;
    @(negedge clk);
    start = cyc;
    if (v.port) begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
    end
    e.port = v.port; e.rdata = v.exp_rdata; e.err = v.exp_err; e.chk_rdata = v.chk_rdata;
    sb.push_back(e);
    wait_gnt(6, port, at);
    m0_req = 1'b0;
    m1_req = 1'b0;
    aligned = (v.addr[2:0] == 3'b000);
    check64("gnt_port", 64'(port), 64'(v.port));
    check64("gnt_latency", 64'(at - start), 64'd1);
    check64("gnt_exclusive", 64'(m0_gnt & m1_gnt), 64'd0);
    check64("mem_read", 64'(mem_read), 64'(!v.we && aligned));
    check64("mem_write", 64'(mem_write), 64'(v.we && aligned));
    check64("endereco", 64'(endereco), 64'(v.addr));
    if (v.we) check64("write_data", write_data, v.wdata);
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    check64(name, act, exp);
  endtask

  initial begin
    int port, at, prev, start;
    bit exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    vecs[0]  = '{1'b0, 1'b0, 8'h00, 64'h0, 64'h0000000000000008, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 8'h10, 64'hDEADBEEF01234567, 64'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h10, 64'h0, 64'hDEADBEEF01234567, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'h0B, 64'h0, 64'h0, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h08, 64'h0, 64'h0000000000000006, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'h0C, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 8'h08, 64'h0, 64'h0000000000000006, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'h20, 64'h0123456789ABCDEF, 64'h0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h20, 64'h0, 64'h0123456789ABCDEF, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h18, 64'h0, 64'h1122334455667788, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 8'h18, 64'h0, 64'h1122334455667788, 1'b0, 1'b1};

    reset = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    #1;
    check_output("rst_gnt", 64'({m0_gnt, m1_gnt}), 64'd0);
    check_output("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
    check_output("rst_err", 64'({m0_err, m1_err}), 64'd0);
    check_output("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
    check_output("rst_endereco", 64'(endereco), 64'd0);
    check_output("rst_write_data", write_data, 64'd0);
    check_output("rst_m0_rdata", m0_rdata, 64'd0);
    check_output("rst_m1_rdata", m1_rdata, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) apply_stimulus(vecs[i]);
    check_output("mem_byte_10", 64'(mem[8'h10]), 64'hDE);
    check_output("mem_byte_17", 64'(mem[8'h17]), 64'h67);
    check_output("m0_rdata_hold", m0_rdata, 64'h1122334455667788);

    // Reset lands between the rising edge into ACCESS and the falling write edge.
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h08; m0_wdata = 64'hAAAAAAAAAAAAAAAA;
    @(posedge clk);
    #1;
    check_output("midrst_write_armed", 64'(mem_write), 64'd1);
    reset = 1'b1;
    #1;
    check_output("midrst_mem_write", 64'(mem_write), 64'd0);
    check_output("midrst_gnt", 64'({m0_gnt, m1_gnt}), 64'd0);
    check_output("midrst_rdata", m0_rdata | m1_rdata, 64'd0);
    check_output("midrst_endereco", 64'(endereco), 64'd0);
    m0_req = 1'b0; m0_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_output("midrst_mem_08", 64'(mem[8'h08]), 64'h00);
    check_output("midrst_mem_0f", 64'(mem[8'h0F]), 64'h06);

    // Persistent tie straight out of reset: port 0 first, then strict alternation.
    @(negedge clk);
    start = cyc;
    m0_req = 1'b1; m0_addr = 8'h00;
    m1_req = 1'b1; m1_addr = 8'h08; m1_we = 1'b0;
    for (int i = 0; i < 4; i++)
      push_exp(exp_order[i], exp_order[i] ? 64'h6 : 64'h8, 1'b0);
    prev = start - 2;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(6, port, at);
      if (i == 3) begin m0_req = 1'b0; m1_req = 1'b0; end
      check_output("tie_order", 64'(port), 64'(exp_order[i]));
      check_output("tie_spacing", 64'(at - prev), 64'd3);
      prev = at;
    end
    repeat (2) @(negedge clk);

    // m0 holds req through RESP, then m1 arrives in the following IDLE cycle.
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 8'h00;
    push_exp(1'b0, 64'h8, 1'b0);
    wait_gnt(6, port, prev);
    check_output("hold_first", 64'(port), 64'd0);
    push_exp(1'b0, 64'h8, 1'b0);
    wait_gnt(6, port, at);
    check_output("hold_second", 64'(port), 64'd0);
    check_output("hold_spacing", 64'(at - prev), 64'd3);
    prev = at;
    repeat (2) @(negedge clk);
    m1_req = 1'b1; m1_addr = 8'h08;
    push_exp(1'b1, 64'h6, 1'b0);
    wait_gnt(6, port, at);
    m1_req = 1'b0;
    check_output("late_m1_wins", 64'(port), 64'd1);
    check_output("late_m1_spacing", 64'(at - prev), 64'd3);
    push_exp(1'b0, 64'h8, 1'b0);
    wait_gnt(6, port, at);
    m0_req = 1'b0;
    check_output("m0_after_m1", 64'(port), 64'd0);
    repeat (2) @(negedge clk);

    apply_stimulus('{1'b0, 1'b0, 8'h08, 64'h0, 64'h0000000000000006, 1'b0, 1'b1});
    repeat (3) @(negedge clk);
    check_output("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the byte-addressed, 256-byte data memory (64-bit big-endian doubleword, combinational read, write on falling clock edge). It sits between the memory and two requesters: port 0 is the datapath load/store unit and port 1 is the debug/loader port. It grants one doubleword access at a time with round-robin fairness and drives the memory's `mem_read`, `mem_write`, `endereco` and `write_data` inputs from registers. It returns read data, or a write acknowledge, to the winning requester.

## Interface
- `ADDR_WIDTH`, 8, memory byte-address width.
- `DATA_WIDTH`, 64, access width; fixed at one doubleword.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high.
- `m0_req`, `m1_req` in 1: access request; level, held until grant.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read; qualified by req.
- `m0_addr`, `m1_addr` in ADDR_WIDTH: byte address of doubleword.
- `m0_wdata`, `m1_wdata` in DATA_WIDTH: store data.
- `m0_gnt`, `m1_gnt` out 1: request accepted (1-cycle pulse).
- `m0_rvalid`, `m1_rvalid` out 1: access complete (1-cycle pulse).
- `m0_rdata`, `m1_rdata` out DATA_WIDTH: load data; valid while rvalid.
- `m0_err`, `m1_err` out 1: misaligned access; valid while rvalid.
- `mem_read`, `mem_write` out 1: to memory.
- `endereco` out ADDR_WIDTH: to memory address.
- `write_data` out DATA_WIDTH: to memory.
- `read_data` in DATA_WIDTH: from memory.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE→ACCESS when any req=1 at the rising edge.
  - ACCESS→RESP unconditionally.
  - RESP→IDLE unconditionally.
- Arbitration happens only in IDLE:
  - Exactly one req high: that port wins.
  - Both high: the port not served last wins.
  - `last` pointer resets to 1, so port 0 wins the first tie.
  - `last` updates to the winner on every grant.
- On the IDLE→ACCESS edge, latch the winner id, we, addr and wdata. Requesters may change inputs afterwards.
- ACCESS:
  - `mN_gnt`=1 for the winner.
  - `endereco` = latched addr.
  - `write_data` = latched wdata.
  - `mem_read` = !we and `mem_write` = we, both only when aligned.
- Alignment rule: addr[2:0] must be 000.
  - A misaligned access is still granted, but `mem_read` and `mem_write` stay 0.
  - RESP then asserts `mN_err`=1 and `mN_rdata`=0.
- Memory commits a write on the falling edge inside ACCESS.
- `read_data` is captured into `mN_rdata` on the ACCESS→RESP edge. The non-winner's rdata holds its previous value.
- RESP: `mN_rvalid`=1 for the winner, on both reads and writes; `mN_err` as above.
- `req` is sampled only in IDLE. A requester must deassert req by the end of its RESP cycle. A req still high in IDLE starts a new access.
- Reset (async, any state) forces:
  - state=IDLE, `last`=1;
  - all gnt, rvalid and err = 0;
  - `mem_read`, `mem_write` = 0;
  - `endereco`=0, `write_data`=0, both rdata = 0.
- Reset asserted during ACCESS before the falling edge drops `mem_write` immediately, so no write occurs.

## Timing
- All outputs are registered or decoded from state and latched registers only. There is no combinational path from req or addr to the memory or gnt.
- Request sampled at edge k:
  - ACCESS (gnt) during cycle k+1;
  - RESP (rvalid) during cycle k+2;
  - IDLE during cycle k+3.
- Throughput: one access per 3 cycles with continuous requests. Under a persistent tie, ports alternate 0,1,0,1.
- Read-after-write to the same address, issued by either port in the next access, returns the new data.

## Test plan
- Reset, then m0 read at addr 0x00 (memory holds 0x0000000000000008 there) → m0_gnt in cycle 1, m0_rvalid in cycle 2 with rdata=0x8, m0_err=0; m1 outputs stay 0.
- m1 write 0xDEADBEEF01234567 to 0x10, then m0 read 0x10 → m1_rvalid pulses; m0_rdata=0xDEADBEEF01234567; memory byte 0x10=0xDE and byte 0x17=0x67.
- Both req high continuously for 4 accesses from reset → grant order 0,1,0,1, each access 3 cycles apart.
- m0 read at 0x0B (misaligned) → m0_gnt=1, mem_read never 1, m0_rvalid=1 with m0_err=1 and rdata=0; next aligned access has err=0.
- Assert reset mid-ACCESS of a write to 0x08 before the falling edge → mem_write drops at once; afterwards the read of 0x08 returns the old 0x6; FSM is in IDLE and the next tie is granted to m0.
- m0 holds req through RESP → a second m0 access starts after one IDLE cycle; m1 arriving in that IDLE cycle wins instead (last=0).
